// File: rtl/mem_map_ctrl_pkg.sv
// Shared constants for the memory-map controller: FSM states,
// region indices and the per-region wait-field width.
package mem_map_ctrl_pkg;

  localparam int WAIT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int RGN_DATA  = 0;
  localparam int RGN_STACK = 1;
  localparam int RGN_VGA   = 2;
  localparam int RGN_IO    = 3;

endpackage

// File: rtl/mem_map_ctrl_wait_cnt.sv
// Down-counter timing the ACCESS phase; zero flags the last
// wait cycle of a region access.
module mem_map_wait_cnt
  import mem_map_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] value,
  output logic              zero
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_map_ctrl.sv
// CPU-to-region memory map controller with per-region wait states.
// Define MEM_MAP_CTRL_FAULT_EN to add sticky invalid-region fault capture.
module mem_map_ctrl
  import mem_map_ctrl_pkg::*;
#(
  parameter int                     WIDTH     = 32,
  parameter int                     ADDR_W    = 16,
  parameter int                     LOCAL_W   = 14,
  parameter int                     NREG      = 4,
  parameter logic [NREG*WAIT_W-1:0] WAITS     = {4'd3, 4'd1, 4'd1, 4'd1},
  parameter logic [NREG-1:0]        REG_VALID = 4'b1111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  busy,
  output logic [LOCAL_W-1:0]    rgn_addr,
  output logic [WIDTH-1:0]      rgn_wdata,
  output logic [NREG-1:0]       rgn_en,
  output logic [NREG-1:0]       rgn_we,
  input  logic [NREG*WIDTH-1:0] rgn_rdata
`ifdef MEM_MAP_CTRL_FAULT_EN
  ,
  output logic                  fault,
  output logic [ADDR_W-1:0]     fault_addr
`endif
);

  localparam int RW = ADDR_W - LOCAL_W;

  logic [1:0]         state_q, state_d;
  logic [RW-1:0]      rgn_q, rgn_d;
  logic               we_q, we_d;
  logic               first_q, first_d;
  logic [LOCAL_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;

  logic [RW-1:0]      req_rgn;
  logic [WAIT_W-1:0]  cnt_val;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic               hit_ok;
  logic               in_access;
  logic [NREG-1:0]    sel;

  assign req_rgn   = addr[ADDR_W-1:LOCAL_W];
  assign hit_ok    = REG_VALID[rgn_q];
  assign in_access = (state_q == ACCESS);
  assign sel       = {{(NREG-1){1'b0}}, 1'b1} << rgn_q;

  // Unmapped regions complete with no wait states.
  assign cnt_val = REG_VALID[req_rgn] ?
                   WAITS[req_rgn*WAIT_W +: WAIT_W] : '0;

  always_comb begin
    state_d  = state_q;
    rgn_d    = rgn_q;
    we_d     = we_q;
    first_d  = first_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          rgn_d    = req_rgn;
          we_d     = we;
          addr_d   = addr[LOCAL_W-1:0];
          wdata_d  = wdata;
          first_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        first_d = 1'b0;
        if (cnt_zero) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = hit_ok ?
                      rgn_rdata[rgn_q*WIDTH +: WIDTH] : '0;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rgn_q   <= '0;
      we_q    <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rgn_q   <= rgn_d;
      we_q    <= we_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mem_map_wait_cnt u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  assign rdata     = rdata_q;
  assign ready     = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rgn_addr  = addr_q;
  assign rgn_wdata = wdata_q;
  assign rgn_en    = (in_access && hit_ok) ? sel : '0;
  assign rgn_we    = (in_access && hit_ok && first_q && we_q) ? sel : '0;

`ifdef MEM_MAP_CTRL_FAULT_EN
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  // Sticky: the first offending address is kept until reset.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (in_access && cnt_zero && !hit_ok) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        fault_addr_d = {rgn_q, addr_q};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
`endif

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Bench for mem_map_ctrl: a fully mapped instance and one with
// region 3 unmapped, checked against a cycle-count model.
module tb_mem_map_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req = '0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [127:0] rgn_rdata =
    {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_0001};

  logic [1:0][31:0] rdata;
  logic [1:0]       ready, busy;
  logic [1:0][13:0] rgn_addr;
  logic [1:0][31:0] rgn_wdata;
  logic [1:0][3:0]  rgn_en, rgn_we;
`ifdef MEM_MAP_CTRL_FAULT_EN
  logic [1:0]       fault;
  logic [1:0][15:0] fault_addr;
`endif

  mem_map_ctrl dut0 (
    .clk(clk), .reset(rst), .req(req[0]), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]),
    .rgn_addr(rgn_addr[0]), .rgn_wdata(rgn_wdata[0]),
    .rgn_en(rgn_en[0]), .rgn_we(rgn_we[0]),
    .rgn_rdata(rgn_rdata)
`ifdef MEM_MAP_CTRL_FAULT_EN
    , .fault(fault[0]), .fault_addr(fault_addr[0])
`endif
  );

  mem_map_ctrl #(.REG_VALID(4'b0111)) dut1 (
    .clk(clk), .reset(rst), .req(req[1]), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]),
    .rgn_addr(rgn_addr[1]), .rgn_wdata(rgn_wdata[1]),
    .rgn_en(rgn_en[1]), .rgn_we(rgn_we[1]),
    .rgn_rdata(rgn_rdata)
`ifdef MEM_MAP_CTRL_FAULT_EN
    , .fault(fault[1]), .fault_addr(fault_addr[1])
`endif
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase counts cycles since acceptance (0 = idle).
  int          ph[2]   = '{0, 0};
  int          lat[2]  = '{0, 0};
  int          m_r[2]  = '{0, 0};
  logic        m_v[2]  = '{1'b0, 1'b0};
  logic        m_we[2] = '{1'b0, 1'b0};
  logic [15:0] m_a[2]  = '{16'h0, 16'h0};
  logic [31:0] m_wd[2] = '{32'h0, 32'h0};
  logic [31:0] m_rd[2] = '{32'h0, 32'h0};
  logic        m_f[2]  = '{1'b0, 1'b0};
  logic [15:0] m_fa[2] = '{16'h0, 16'h0};

  function automatic logic mapped(input int i, input int r);
    return (i == 0) || (r != 3);
  endfunction

  function automatic int waits_of(input int r);
    return (r == 3) ? 3 : 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] = 0; m_a[i] = '0; m_wd[i] = '0;
        m_rd[i] = '0; m_f[i] = 1'b0; m_fa[i] = '0;
      end else if (ph[i] == 0) begin
        if (req[i]) begin
          m_r[i]  = int'(addr[15:14]);
          m_v[i]  = mapped(i, m_r[i]);
          lat[i]  = m_v[i] ? waits_of(m_r[i]) : 0;
          m_we[i] = we;
          m_a[i]  = addr;
          m_wd[i] = wdata;
          ph[i]   = 1;
        end
      end else begin
        if (ph[i] == lat[i] + 1) begin
          if (!m_we[i])
            m_rd[i] = m_v[i] ? rgn_rdata[m_r[i]*32 +: 32] : 32'h0;
          if (!m_v[i]) begin
            if (!m_f[i]) m_fa[i] = m_a[i];
            m_f[i] = 1'b1;
          end
        end
        ph[i] = (ph[i] == lat[i] + 2) ? 0 : ph[i] + 1;
      end
    end
  end

  int en_cnt[2] = '{0, 0};
  int we_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] oh;
      logic       acc;
      oh  = 4'b0001 << m_r[i];
      acc = ph[i] >= 1 && ph[i] <= lat[i] + 1 && m_v[i];
      chk("busy", busy[i], ph[i] != 0);
      chk("ready", ready[i], ph[i] != 0 && ph[i] == lat[i] + 2);
      chk("rgn_en", rgn_en[i], acc ? oh : 4'b0);
      chk("rgn_we", rgn_we[i], (acc && ph[i] == 1 && m_we[i]) ? oh : 4'b0);
      chk("rgn_addr", rgn_addr[i], m_a[i][13:0]);
      chk("rgn_wdata", rgn_wdata[i], m_wd[i]);
      chk("rdata", rdata[i], m_rd[i]);
`ifdef MEM_MAP_CTRL_FAULT_EN
      chk("fault", fault[i], m_f[i]);
      chk("fault_addr", fault_addr[i], m_fa[i]);
`endif
      if (rgn_en[i] != 0) en_cnt[i]++;
      if (rgn_we[i] != 0) we_cnt[i]++;
    end
  end

  // One request pulse; n = cycles from request to ready.
  task automatic xfer(input int i, input logic [15:0] a, input logic w,
                      input logic [31:0] d, output int n);
    @(posedge clk); #1;
    addr = a; we = w; wdata = d; req[i] = 1'b1;
    en_cnt[i] = 0; we_cnt[i] = 0; n = 0;
    do begin
      @(posedge clk); #1;
      req[i] = 1'b0;
      n++;
    end while (!ready[i] && n < 20);
    chk("ready_seen", ready[i], 1'b1);
  endtask

  int n;
  int p[3];
  int pulses, idle;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_ready", ready[0], 1'b0);
    chk("rst_en", rgn_en[0], 4'h0);
    chk("rst_addr", rgn_addr[0], 14'h0);
    @(negedge clk) rst = 1'b0;

    xfer(0, 16'h0004, 1'b0, 32'h0, n);
    chk("t1_lat", n, 3);
    chk("t1_rdata", rdata[0], 32'hCAFE0001);
    chk("t1_en_cyc", en_cnt[0], 2);

    xfer(0, 16'hC010, 1'b1, 32'h5A, n);
    chk("t2_lat", n, 5);
    chk("t2_we_cyc", we_cnt[0], 1);
    chk("t2_en_cyc", en_cnt[0], 4);
    chk("t2_addr", rgn_addr[0], 14'h0010);
    chk("t2_wdata", rgn_wdata[0], 32'h5A);
    chk("t2_rdata_hold", rdata[0], 32'hCAFE0001);

    @(posedge clk); #1;
    addr = 16'h4008; we = 1'b0; req[0] = 1'b1;
    n = 0; pulses = 0; idle = 0;
    while (pulses < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready[0]) begin
        p[pulses] = n;
        pulses++;
      end else if (pulses >= 1 && !busy[0]) begin
        idle++;
      end
    end
    req[0] = 1'b0;
    chk("t3_pulses", pulses, 3);
    chk("t3_first", p[0], 3);
    chk("t3_gap1", p[1] - p[0], 4);
    chk("t3_gap2", p[2] - p[1], 4);
    chk("t3_idle", idle, 2);
    chk("t3_rdata", rdata[0], 32'h11110001);

    @(posedge clk); #1;
    addr = 16'hC123; we = 1'b0; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("t4_pre_en", rgn_en[0], 4'b1000);
    rst = 1'b1;
    #1;
    chk("t4_rdata", rdata[0], 32'h0);
    chk("t4_busy", busy[0], 1'b0);
    chk("t4_ready", ready[0], 1'b0);
    chk("t4_en", rgn_en[0], 4'h0);
    chk("t4_we", rgn_we[0], 4'h0);
    chk("t4_addr", rgn_addr[0], 14'h0);
    chk("t4_wdata", rgn_wdata[0], 32'h0);
    @(negedge clk) rst = 1'b0;
    xfer(0, 16'hC123, 1'b0, 32'h0, n);
    chk("t4_lat", n, 5);
    chk("t4_rd", rdata[0], 32'h33330003);

    xfer(1, 16'h0004, 1'b0, 32'h0, n);
    chk("t5_ok_lat", n, 3);
    chk("t5_ok_rd", rdata[1], 32'hCAFE0001);
    xfer(1, 16'hFFFF, 1'b0, 32'h0, n);
    chk("t5_lat", n, 2);
    chk("t5_en_cyc", en_cnt[1], 0);
    chk("t5_rdata", rdata[1], 32'h0);
`ifdef MEM_MAP_CTRL_FAULT_EN
    chk("t5_fault", fault[1], 1'b1);
    chk("t5_faddr", fault_addr[1], 16'hFFFF);
`endif
    xfer(1, 16'hC004, 1'b0, 32'h0, n);
    chk("t5_lat2", n, 2);
`ifdef MEM_MAP_CTRL_FAULT_EN
    chk("t5_faddr_keep", fault_addr[1], 16'hFFFF);
    chk("t5_fault0", fault[0], 1'b0);
`endif
    xfer(0, 16'hFFFF, 1'b0, 32'h0, n);
    chk("t5_top_lat", n, 5);
    chk("t5_top_rd", rdata[0], 32'h33330003);
    chk("t5_top_addr", rgn_addr[0], 14'h3FFF);

    @(posedge clk); #1;
    addr = 16'h0001; we = 1'b0; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0; addr = 16'h4001; we = 1'b1; wdata = 32'hDEAD;
    chk("t6_addr_a1", rgn_addr[0], 14'h0001);
    chk("t6_en_a1", rgn_en[0], 4'b0001);
    @(posedge clk); #1;
    chk("t6_addr_a2", rgn_addr[0], 14'h0001);
    chk("t6_en_a2", rgn_en[0], 4'b0001);
    chk("t6_we_a2", rgn_we[0], 4'b0000);
    @(posedge clk); #1;
    chk("t6_ready", ready[0], 1'b1);
    chk("t6_addr_resp", rgn_addr[0], 14'h0001);
    chk("t6_rdata", rdata[0], 32'hCAFE0001);
    we = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mem_map_ctrl.md
MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be:
  WIDTH, 32, data width
  ADDR_W, 16, CPU address width
  LOCAL_W, 14, region-local address width; region index = addr[ADDR_W-1:LOCAL_W]
  NREG, 4, region count, equal to 2**(ADDR_W-LOCAL_W)
  WAITS, {4'd3,4'd1,4'd1,4'd1}, per-region wait cycles, 4 bits each, region 0 in LSBs
  REG_VALID, 4'b1111, per-region valid mask
REQ-003 Ports SHALL be:
  clk  in  1  clock
  reset  in  1  async active-high reset
  req  in  1  CPU access request
  we  in  1  write (1) / read (0)
  addr  in  ADDR_W  CPU byte/word address
  wdata  in  WIDTH  CPU write data
  rdata  out  WIDTH  registered read data, valid while ready=1
  ready  out  1  one-cycle completion strobe
  busy  out  1  high in any state except IDLE
  rgn_addr  out  LOCAL_W  registered local address
  rgn_wdata  out  WIDTH  registered write data
  rgn_en  out  NREG  one-hot region enable
  rgn_we  out  NREG  one-hot region write strobe
  rgn_rdata  in  NREG*WIDTH  packed region read data, region 0 in LSBs

Function
REQ-004 States SHALL be IDLE, ACCESS, RESP.
REQ-005 In IDLE with req=1, the block SHALL latch addr[LOCAL_W-1:0], wdata, we and the region index r, load the wait counter with WAITS[r], and enter ACCESS next cycle.
REQ-006 In ACCESS, rgn_en[r] SHALL be 1; rgn_we[r] SHALL be 1 only in the first ACCESS cycle and only for writes; all other enable bits SHALL be 0.
REQ-007 ACCESS SHALL last WAITS[r]+1 cycles; the counter decrements each cycle, and the block enters RESP on the cycle after it reads 0.
REQ-008 On the edge leaving ACCESS, rdata SHALL capture slice r of rgn_rdata for reads; for writes rdata SHALL hold its previous value.
REQ-009 Regions with synchronous read SHALL be configured with WAITS >= 1; WAITS=0 means combinational read.
REQ-010 RESP SHALL last one cycle with ready=1 and SHALL always return to IDLE. Request-to-ready latency is WAITS[r]+2 cycles, and back-to-back throughput is one access per WAITS[r]+3 cycles.
REQ-011 Changes on req/addr/we/wdata after acceptance SHALL be ignored until IDLE; a request held high through RESP is accepted again in the following IDLE cycle.
REQ-012 Access to a region with REG_VALID[r]=0 SHALL assert no rgn_en/rgn_we bit, SHALL use zero wait cycles, and SHALL return rdata=0 for reads.
REQ-013 The highest address (all ones) SHALL decode to region NREG-1 with no wrap or overflow.

Reset
REQ-014 While reset=1, state=IDLE, counter=0, and ready, busy, rgn_en, rgn_we, rgn_addr, rgn_wdata and rdata SHALL all be 0, regardless of any access in progress.
REQ-015 After reset deasserts, the first request SHALL be accepted on the first rising edge with req=1.

Configuration
REQ-016 With MEM_MAP_CTRL_FAULT_EN defined, ports fault (out, 1) and fault_addr (out, ADDR_W) SHALL exist:
  - an invalid-region access sets sticky fault=1 and records its full address in fault_addr in the RESP cycle;
  - only reset clears them;
  - the first fault's address is retained on later faults.
REQ-017 Without MEM_MAP_CTRL_FAULT_EN, these ports and registers SHALL be absent and invalid accesses behave per REQ-012 only.

Structure
REQ-018 Package mem_map_ctrl_pkg SHALL hold:
  - the state enumeration (IDLE, ACCESS, RESP);
  - the region index constants (RGN_DATA=0, RGN_STACK=1, RGN_VGA=2, RGN_IO=3);
  - the 4-bit wait-field width.
REQ-019 The wait counter SHALL be a sub-module mem_map_wait_cnt with ports load, value and zero.

Verification
REQ-020 Bench SHALL cover:
  - Read addr=16'h0004, region 0 returns 32'hCAFE0001, WAITS=1 -> ready 3 cycles after req, rdata=32'hCAFE0001, rgn_en=4'b0001 for 2 cycles.
  - Write addr=16'hC010, wdata=32'h5A -> rgn_we=4'b1000 for exactly 1 cycle, rgn_addr=14'h0010, ready 5 cycles after req.
  - req held high for 3 reads to region 1 -> ready pulses every 4 cycles, busy low exactly 1 cycle between pulses.
  - reset asserted in the 2nd ACCESS cycle of an IO read -> all outputs 0 immediately, next req completes normally.
  - REG_VALID=4'b0111, read addr=16'hFFFF -> no enable bit, rdata=0, ready 2 cycles after req; with MEM_MAP_CTRL_FAULT_EN, fault=1 and fault_addr=16'hFFFF.
  - addr changed during ACCESS from 16'h0001 to 16'h4001 -> rgn_addr and rgn_en unchanged until RESP.
